// File: rtl/udp_payload_extractor.sv
// Pops accepted frames from the UDP filter's FWFT FIFO, strips the 42-byte
// Ethernet/IPv4/UDP header and streams the byte-realigned UDP payload on AXIS.
module udp_payload_extractor #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  s_rst_i,
  input  logic                  frame_valid_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic [7:0]            m_axis_tkeep_o,
  output logic                  m_axis_tlast_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic                  len_err_o,
  output logic [15:0]           frame_cnt_o
);

  localparam int HDR_BYTES = 42;
  localparam logic [2:0] LAST_HDR_BEAT = 3'(HDR_BYTES / 8);
  localparam logic [2:0] LEN_BEAT      = 3'(HDR_BYTES / 8 - 1);

  if (DATA_WIDTH != 64) begin : g_bad_width
    $error("udp_payload_extractor supports DATA_WIDTH=64 only");
  end

  typedef enum logic [2:0] {IDLE, HDR, PAY, DRAIN, WAIT_CLR} state_t;

  state_t      state;
  logic [2:0]  beat_cnt;
  logic [15:0] rem;
  logic [47:0] hold;
  logic        out_free;
  logic [15:0] udp_len;

  // Header is 42 bytes, so payload byte 0 sits at bits [63:16] of beat 5.
  assign out_free = !m_axis_tvalid_o || m_axis_tready_i;
  assign udp_len  = {fifo_data_i[55:48], fifo_data_i[63:56]};

  function automatic logic [7:0] keep_for(input logic [15:0] n);
    if (n >= 16'd8) begin
      keep_for = 8'hFF;
    end else begin
      keep_for = 8'hFF >> (4'd8 - 4'(n));
    end
  endfunction

  // FWFT pop: the head word is consumed in the same cycle it is used.
  always_comb begin
    fifo_rd_en_o = 1'b0;
    case (state)
      HDR, DRAIN: fifo_rd_en_o = !fifo_empty_i;
      PAY:        fifo_rd_en_o = out_free && !fifo_empty_i && (rem > 16'd6);
      default:    fifo_rd_en_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state           <= IDLE;
      beat_cnt        <= 3'd0;
      rem             <= 16'd0;
      hold            <= 48'd0;
      m_axis_tdata_o  <= 64'd0;
      m_axis_tkeep_o  <= 8'd0;
      m_axis_tlast_o  <= 1'b0;
      m_axis_tvalid_o <= 1'b0;
      len_err_o       <= 1'b0;
      frame_cnt_o     <= 16'd0;
    end else begin
      len_err_o <= 1'b0;
      if (m_axis_tvalid_o && m_axis_tready_i) begin
        m_axis_tvalid_o <= 1'b0;
        if (m_axis_tlast_o) begin
          frame_cnt_o <= frame_cnt_o + 16'd1;
        end
      end
      case (state)
        IDLE: begin
          if (frame_valid_i && !fifo_empty_i) begin
            state    <= HDR;
            beat_cnt <= 3'd0;
          end
        end
        HDR: begin
          if (fifo_empty_i) begin
            len_err_o <= 1'b1;
            state     <= WAIT_CLR;
          end else begin
            beat_cnt <= beat_cnt + 3'd1;
            if (beat_cnt == LEN_BEAT) begin
              rem <= udp_len - 16'd8;
              if (udp_len < 16'd8) begin
                len_err_o <= 1'b1;
                state     <= DRAIN;
              end else if (udp_len == 16'd8) begin
                state <= DRAIN;
              end
            end else if (beat_cnt == LAST_HDR_BEAT) begin
              hold  <= fifo_data_i[63:16];
              state <= PAY;
            end
          end
        end
        PAY: begin
          if (out_free) begin
            m_axis_tvalid_o <= 1'b1;
            if (rem <= 16'd6) begin
              // Remaining bytes already sit in hold.
              m_axis_tdata_o <= {16'd0, hold};
              m_axis_tkeep_o <= keep_for(rem);
              m_axis_tlast_o <= 1'b1;
              state          <= DRAIN;
            end else if (fifo_empty_i) begin
              m_axis_tdata_o <= {16'd0, hold};
              m_axis_tkeep_o <= 8'h3F;
              m_axis_tlast_o <= 1'b1;
              len_err_o      <= 1'b1;
              state          <= DRAIN;
            end else begin
              m_axis_tdata_o <= {fifo_data_i[15:0], hold};
              hold           <= fifo_data_i[63:16];
              if (rem <= 16'd8) begin
                m_axis_tkeep_o <= keep_for(rem);
                m_axis_tlast_o <= 1'b1;
                state          <= DRAIN;
              end else begin
                m_axis_tkeep_o <= 8'hFF;
                m_axis_tlast_o <= 1'b0;
                rem            <= rem - 16'd8;
              end
            end
          end
        end
        DRAIN: begin
          if (fifo_empty_i) begin
            state <= WAIT_CLR;
          end
        end
        WAIT_CLR: begin
          if (!frame_valid_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_payload_extractor.sv
// Randomised scoreboard bench: a byte-level frame model predicts payload beats,
// a separate monitor checks every AXIS handshake, stall stability and counters.
module tb_udp_payload_extractor;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        s_rst_i = 1'b1;
  logic        frame_valid_i = 1'b0;
  logic        fifo_rd_en_o;
  logic [63:0] fifo_data_i = 64'd0;
  logic        fifo_empty_i = 1'b1;
  logic [63:0] m_axis_tdata_o;
  logic [7:0]  m_axis_tkeep_o;
  logic        m_axis_tlast_o;
  logic        m_axis_tvalid_o;
  logic        m_axis_tready_i = 1'b1;
  logic        len_err_o;
  logic [15:0] frame_cnt_o;

  int          total = 0;
  int          bad = 0;
  int          err_exp = 0;
  int          err_seen = 0;
  int          rdy_mode = 0;
  logic        pop_pending = 1'b0;
  logic [63:0] fifo_q[$];
  beat_t       exp_q[$];

  udp_payload_extractor #(.DATA_WIDTH(64)) dut (
    .clk_i(clk), .s_rst_i(s_rst_i), .frame_valid_i(frame_valid_i),
    .fifo_rd_en_o(fifo_rd_en_o), .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i),
    .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tkeep_o(m_axis_tkeep_o),
    .m_axis_tlast_o(m_axis_tlast_o), .m_axis_tvalid_o(m_axis_tvalid_o),
    .m_axis_tready_i(m_axis_tready_i), .len_err_o(len_err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] keep_mask(input logic [7:0] k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic refresh();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = fifo_empty_i ? 64'd0 : fifo_q[0];
  endtask

  // Called at posedge+2; returns at the next posedge+2 with the FIFO updated.
  task automatic tick();
    #6;
    pop_pending = fifo_rd_en_o;
    @(posedge clk);
    #1;
    if (pop_pending === 1'b1 && !s_rst_i) begin
      total++;
      if (fifo_q.size() == 0) begin
        bad++;
        $display("FAIL fifo_overpop got=pop_on_empty exp=no_pop");
      end else begin
        void'(fifo_q.pop_front());
      end
    end
    refresh();
    #1;
    case (rdy_mode)
      0:       m_axis_tready_i = 1'b1;
      1:       m_axis_tready_i = ~m_axis_tready_i;
      default: m_axis_tready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send_frame(input int nb, input logic [15:0] udp, input int rmode, input int rst_at);
    logic [7:0] fb[];
    int avail, nout, cyc, sz, l;
    beat_t b;
    fb = new[nb * 8];
    foreach (fb[i]) fb[i] = 8'($urandom);
    if (nb * 8 > 39) begin
      fb[38] = udp[15:8];
      fb[39] = udp[7:0];
    end
    avail = nb * 8 - 42;
    nout = 0;
    l = int'(udp) - 8;
    if (nb < 5) err_exp++;
    else if (udp < 16'd8) err_exp++;
    else if (nb == 5) begin
      if (udp != 16'd8) err_exp++;
    end else if (l <= avail) nout = l;
    else begin
      nout = avail;
      err_exp++;
    end
    for (int off = 0; off < nout; off += 8) begin
      sz = (nout - off < 8) ? nout - off : 8;
      b.data = 64'd0;
      b.keep = 8'd0;
      for (int k = 0; k < sz; k++) begin
        b.data[8*k +: 8] = fb[42 + off + k];
        b.keep[k] = 1'b1;
      end
      b.last = (off + 8 >= nout);
      exp_q.push_back(b);
    end
    for (int w = 0; w < nb; w++) begin
      logic [63:0] word;
      for (int k = 0; k < 8; k++) word[8*k +: 8] = fb[8*w + k];
      fifo_q.push_back(word);
    end
    refresh();
    rdy_mode = rmode;
    frame_valid_i = 1'b1;
    cyc = 0;
    while (fifo_q.size() != 0 && cyc < 5000) begin
      tick();
      cyc++;
      if (cyc == rst_at) begin
        s_rst_i = 1'b1;
        fifo_q.delete();
        frame_valid_i = 1'b0;
        refresh();
        tick();
        s_rst_i = 1'b0;
      end
    end
    total++;
    if (cyc >= 5000) begin
      bad++;
      $display("FAIL drain_timeout got=%0d_words_left exp=0", fifo_q.size());
    end
    frame_valid_i = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      tick();
      cyc++;
    end
    repeat (3) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL output_timeout got=%0d_beats_pending exp=0", exp_q.size());
    end
    total++;
    if (err_seen != err_exp) begin
      bad++;
      $display("FAIL len_err_count got=%0d exp=%0d", err_seen, err_exp);
    end
  endtask

  // Monitor: checks reset state, stall stability and every handshake.
  initial begin
    logic        rst_chk = 1'b0;
    logic        stall = 1'b0;
    beat_t       sb;
    beat_t       e;
    logic [15:0] exp_cnt = 16'd0;
    logic [63:0] m;
    forever begin
      @(negedge clk);
      if (rst_chk) begin
        rst_chk = 1'b0;
        exp_cnt = 16'd0;
        total++;
        if (m_axis_tvalid_o !== 1'b0 || frame_cnt_o !== 16'd0 || m_axis_tkeep_o !== 8'd0 ||
            m_axis_tdata_o !== 64'd0 || len_err_o !== 1'b0 || m_axis_tlast_o !== 1'b0 ||
            fifo_rd_en_o !== 1'b0) begin
          bad++;
          $display("FAIL reset_state got=v%b c%h k%h l%b e%b r%b exp=all_zero", m_axis_tvalid_o,
                   frame_cnt_o, m_axis_tkeep_o, m_axis_tlast_o, len_err_o, fifo_rd_en_o);
        end
      end
      if (s_rst_i) begin
        exp_q.delete();
        rst_chk = 1'b1;
        stall = 1'b0;
        continue;
      end
      if (len_err_o === 1'b1) err_seen++;
      if (stall) begin
        total++;
        if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== sb.data ||
            m_axis_tkeep_o !== sb.keep || m_axis_tlast_o !== sb.last) begin
          bad++;
          $display("FAIL stall_stable got=v%b %h/%h exp=v1 %h/%h", m_axis_tvalid_o,
                   m_axis_tdata_o, m_axis_tkeep_o, sb.data, sb.keep);
        end
      end
      if (m_axis_tvalid_o === 1'b1 && m_axis_tready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat got=%h/%h exp=none", m_axis_tdata_o, m_axis_tkeep_o);
        end else begin
          e = exp_q.pop_front();
          m = keep_mask(e.keep);
          if (m_axis_tkeep_o !== e.keep || m_axis_tlast_o !== e.last ||
              (m_axis_tdata_o & m) !== e.data) begin
            bad++;
            $display("FAIL beat got=%h k%h l%b exp=%h k%h l%b", m_axis_tdata_o & m,
                     m_axis_tkeep_o, m_axis_tlast_o, e.data, e.keep, e.last);
          end
        end
        total++;
        if (frame_cnt_o !== exp_cnt) begin
          bad++;
          $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt_o, exp_cnt);
        end
        if (m_axis_tlast_o === 1'b1) exp_cnt = exp_cnt + 16'd1;
      end
      stall = (m_axis_tvalid_o === 1'b1) && !m_axis_tready_i;
      sb.data = m_axis_tdata_o;
      sb.keep = m_axis_tkeep_o;
      sb.last = m_axis_tlast_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb, avail, sel;
    logic [15:0] udp;
    @(posedge clk);
    #2;
    repeat (3) tick();
    s_rst_i = 1'b0;
    repeat (2) tick();
    send_frame(8, 16'h0016, 0, 0);
    send_frame(8, 16'h000E, 0, 0);
    send_frame(8, 16'h0008, 0, 0);
    send_frame(8, 16'h0004, 0, 0);
    send_frame(134, 16'h0408, 1, 0);
    send_frame(8, 16'h0100, 0, 0);
    send_frame(4, 16'h0000, 0, 0);
    send_frame(20, 16'd108, 0, 10);
    send_frame(8, 16'h0016, 2, 0);
    for (int i = 0; i < 25; i++) begin
      nb = $urandom_range(6, 20);
      avail = nb * 8 - 42;
      sel = $urandom_range(0, 9);
      if (sel == 0) udp = 16'($urandom_range(0, 7));
      else if (sel == 1) udp = 16'(avail + 8 + $urandom_range(1, 40));
      else udp = 16'(8 + $urandom_range(0, avail));
      send_frame(nb, udp, (i % 2 == 0) ? 0 : 2, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
